multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the processor datapath (PC unit, instruction memory/IR, decoder, register file, ALU, data cache) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Turns the decoder's static control flags into per-cycle strobes.
- Waits on a data-cache ready handshake and guards it with a timeout.
- Counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, max consecutive not-ready MEMORY cycles before ERROR (>=1)
CNT_W, 32, width of instr_count and stall_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin/resume execution (honoured only in IDLE or HALT)
halt_req  in  1  stop after current instruction retires
mem_read_in  in  1  MemRead flag from decoder
mem_write_in  in  1  MemWrite flag from decoder
reg_write_in  in  1  RegWrite flag from decoder
branch_in  in  1  Branch flag from decoder
uncond_in  in  1  Uncondbranch flag from decoder
zero_in  in  1  ALU Zero flag (valid in EXECUTE)
mem_ready  in  1  data cache access complete
ir_load  out  1  latch instruction register
pc_write  out  1  update PC (retire pulse)
pc_src  out  1  1 = branch target, 0 = PC+4; valid when pc_write=1
reg_write_en  out  1  register file write strobe
mem_read_en  out  1  data cache read strobe
mem_write_en  out  1  data cache write strobe
busy  out  1  1 in FETCH..WRITEBACK
state  out  3  current state encoding
timeout_err  out  1  sticky; 1 in ERROR
instr_count  out  CNT_W  retired instruction count, wraps modulo 2^CNT_W
stall_count  out  CNT_W  memory wait-cycle count (see Optional Feature)

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- State is registered. All strobes are decoded combinationally from state plus latched flags, with no extra delay.
- Reset (async, any time, including mid-MEMORY):
  - state=IDLE.
  - All outputs 0: counters, wait counter, latched flags and timeout_err cleared.
- IDLE: start=1 -> FETCH.
- FETCH: ir_load=1 for exactly one cycle -> DECODE.
- DECODE:
  - Latch mem_read_in, mem_write_in, reg_write_in, branch_in, uncond_in into internal flags. Later stages use only the latched copies.
  - If both mem flags are 1, read wins and the latched write flag is cleared.
  - -> EXECUTE.
- EXECUTE:
  - Latch pc_src = (branch & zero_in) | uncond.
  - If read or write flag set -> MEMORY, with the wait counter cleared.
  - Else if reg_write flag set -> WRITEBACK.
  - Else retire.
- MEMORY:
  - mem_read_en or mem_write_en is held high every cycle in this state.
  - If mem_ready=1: read -> WRITEBACK; write -> retire.
  - If mem_ready=0 and wait counter == MEM_TIMEOUT-1 -> ERROR. Otherwise the wait counter increments.
  - So exactly MEM_TIMEOUT consecutive not-ready cycles cause ERROR.
- WRITEBACK: reg_write_en=1 for one cycle, then retire.
- Retire (a transition out of EXECUTE, MEMORY or WRITEBACK):
  - pc_write=1 in that same cycle; pc_src holds its latched value.
  - instr_count increments on that edge.
  - Next state is HALT if halt_req=1 in that cycle, else FETCH.
- HALT: all strobes 0. start=1 -> FETCH.
- ERROR:
  - timeout_err=1; all strobes 0; start is ignored.
  - Exit only via reset.
- start and halt_req are ignored outside the points listed above.
- pc_write is 0 for non-retiring cycles; pc_src reads 0 when pc_write=0.
- Cycle counts per instruction:
  - CBZ/B: 3.
  - R-type/immediate: 4.
  - STUR: 4 + waits.
  - LDUR: 5 + waits.
  - "Waits" = MEMORY cycles with mem_ready=0.

Optional Feature:
- Macro STALL_COUNT_EN.
- When defined: stall_count increments on every MEMORY cycle with mem_ready=0, saturates at 2^CNT_W-1, and clears only on reset.
- When undefined: the stall_count port remains and is tied to 0, and no counter logic is generated.

Test Plan:
1. Reset, then start=1 with an R-type (reg_write_in=1) -> states 1,2,3,5, then 1 again. ir_load high in cycle 1, reg_write_en high in cycle 4, pc_write high in cycle 4; instr_count=1.
2. LDUR with mem_ready low for 3 cycles then high -> mem_read_en high 4 cycles, then WRITEBACK, pc_write on WRITEBACK exit; instr_count=1, stall_count=3 (STALL_COUNT_EN) or 0.
3. CBZ with branch_in=1, zero_in=1 -> retire after EXECUTE, pc_write=1 and pc_src=1 in the same cycle, no reg/mem strobes. Repeat with zero_in=0 -> pc_src=0.
4. STUR with mem_ready never asserted, MEM_TIMEOUT=15 -> 15 MEMORY cycles, then state=7, timeout_err=1. start=1 has no effect; reset returns to IDLE with timeout_err=0.
5. halt_req=1 during the retiring cycle of an R-type -> state=6, no ir_load. start=1 -> FETCH, and instr_count continues from 1.
6. Assert reset mid-MEMORY with mem_read_en=1 -> all outputs 0 immediately, before the next clock edge; state=0, instr_count=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Multi-cycle control FSM for the processor datapath. It walks each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, turns the decoder's static
// control flags into per-cycle strobes, guards the data-cache handshake with a
// timeout, and counts retired instructions.
//
// Optional feature: define STALL_COUNT_EN to build a saturating counter of
// memory wait cycles. Without it, stall_count is tied to 0.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE  (0) | out of reset, waiting for start
// FETCH (1) | ir_load strobe, instruction register captures the instruction
// DECODE(2) | decoder flags latched into internal copies
// EXECUTE(3)| ALU cycle; branch decision latched; may retire (CBZ/B)
// MEMORY(4) | data cache strobe held until mem_ready, watched by timeout
// WRITEBACK5| reg_write_en strobe, then retire
// HALT  (6) | parked after a halt request, start resumes at FETCH
// ERROR (7) | memory timeout; sticky until reset

module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             reg_write_in,
    input  logic             branch_in,
    input  logic             uncond_in,
    input  logic             zero_in,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write_en,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic             busy,
    output logic [2:0]       state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rw_q, rw_d;
    logic              br_q, br_d;
    logic              un_q, un_d;
    logic              pc_src_q, pc_src_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic              retire;

    // State, latched decoder flags and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rw_q     <= 1'b0;
            br_q     <= 1'b0;
            un_q     <= 1'b0;
            pc_src_q <= 1'b0;
            wait_q   <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rw_q     <= rw_d;
            br_q     <= br_d;
            un_q     <= un_d;
            pc_src_q <= pc_src_d;
            wait_q   <= wait_d;
            instr_q  <= instr_d;
        end
    end

    // Next-state logic; retire marks the last cycle of an instruction.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rw_d     = rw_q;
        br_d     = br_q;
        un_d     = un_q;
        pc_src_d = pc_src_q;
        wait_d   = wait_q;
        retire   = 1'b0;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                // A load/store conflict resolves to a load.
                rd_d    = mem_read_in;
                wr_d    = mem_write_in & ~mem_read_in;
                rw_d    = reg_write_in;
                br_d    = branch_in;
                un_d    = uncond_in;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                pc_src_d = (br_q & zero_in) | un_q;
                if (rd_q | wr_q) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else if (rw_q) begin
                    state_d = S_WRITEBACK;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (rd_q) state_d = S_WRITEBACK;
                    else      retire  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: retire = 1'b1;
            S_HALT:    if (start) state_d = S_FETCH;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_IDLE;
        endcase
        if (retire) state_d = halt_req ? S_HALT : S_FETCH;
        instr_d = retire ? instr_q + CNT_W'(1) : instr_q;
    end

    // Strobes decoded from the current state and latched flags.
    always_comb begin
        ir_load      = (state_q == S_FETCH);
        reg_write_en = (state_q == S_WRITEBACK);
        mem_read_en  = (state_q == S_MEMORY) & rd_q;
        mem_write_en = (state_q == S_MEMORY) & ~rd_q;
        busy         = (state_q >= S_FETCH) && (state_q <= S_WRITEBACK);
        timeout_err  = (state_q == S_ERROR);
        pc_write     = retire;
        // pc_src_d carries the fresh decision in EXECUTE and the held one later.
        pc_src       = retire & pc_src_d;
        state        = state_q;
        instr_count  = instr_q;
    end

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating count of MEMORY cycles spent waiting on the cache.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_MEMORY) && !mem_ready && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: each instruction pushes its
// expected retire record; the record is popped when pc_write is seen.
module tb_multicycle_sequencer;
    localparam int CNT_W = 32;
    localparam int MEM_TIMEOUT = 15;
    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_BOTH = 5;

    logic clock = 1'b0;
    logic reset, start, halt_req, mem_read_in, mem_write_in, reg_write_in;
    logic branch_in, uncond_in, zero_in, mem_ready;
    logic ir_load, pc_write, pc_src, reg_write_en, mem_read_en, mem_write_en;
    logic busy, timeout_err;
    logic [2:0] state;
    logic [CNT_W-1:0] instr_count, stall_count;

    typedef struct {
        logic pc_src;
        int   count;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int instr_exp = 0;
    int stall_exp = 0;

    always #5 clock = ~clock;

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .branch_in(branch_in), .uncond_in(uncond_in),
        .zero_in(zero_in), .mem_ready(mem_ready), .ir_load(ir_load),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write_en(reg_write_en),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .busy(busy),
        .state(state), .timeout_err(timeout_err), .instr_count(instr_count),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int stall_ref();
`ifdef STALL_COUNT_EN
        return stall_exp;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flags(input int kind);
        mem_read_in  = (kind == K_LD) || (kind == K_BOTH);
        mem_write_in = (kind == K_ST) || (kind == K_BOTH);
        reg_write_in = (kind == K_R) || (kind == K_LD) || (kind == K_BOTH);
        branch_in    = (kind == K_CBZ);
        uncond_in    = (kind == K_B);
    endtask

    // Runs one instruction starting in FETCH, checking every cycle.
    task automatic run_instr(input int kind, input int waits, input logic zero, input logic halt);
        logic [2:0] seq[$];
        exp_t e, got_e;
        bit is_ld, is_st, last;
        int want_count;
        is_ld = (kind == K_LD) || (kind == K_BOTH);
        is_st = (kind == K_ST);
        seq.push_back(3'd1);
        seq.push_back(3'd2);
        seq.push_back(3'd3);
        if (is_ld || is_st)
            for (int w = 0; w <= waits; w++) seq.push_back(3'd4);
        if (kind == K_R || is_ld) seq.push_back(3'd5);
        set_flags(kind);
        zero_in = zero;
        e.pc_src = (kind == K_CBZ) ? zero : (kind == K_B);
        instr_exp++;
        e.count = instr_exp;
        sb.push_back(e);
        if (is_ld || is_st) stall_exp += waits;
        want_count = -1;
        for (int i = 0; i < seq.size(); i++) begin
            last = (i == seq.size() - 1);
            mem_ready = (seq[i] == 3'd4) && (last || seq[i+1] != 3'd4);
            halt_req = last && halt;
            #1;
            chk("state", state, seq[i]);
            chk("ir_load", ir_load, seq[i] == 3'd1);
            chk("reg_write_en", reg_write_en, seq[i] == 3'd5);
            chk("mem_read_en", mem_read_en, (seq[i] == 3'd4) && is_ld);
            chk("mem_write_en", mem_write_en, (seq[i] == 3'd4) && is_st);
            chk("busy", busy, 1);
            chk("pc_write", pc_write, last);
            if (pc_write) begin
                if (sb.size() > 0) begin
                    got_e = sb.pop_front();
                    chk("pc_src_retire", pc_src, got_e.pc_src);
                    want_count = got_e.count;
                end else begin
                    chk("sb_underflow", sb.size(), 1);
                end
            end else begin
                chk("pc_src_idle", pc_src, 0);
            end
            tick();
        end
        mem_ready = 1'b0;
        halt_req = 1'b0;
        chk("sb_pending", sb.size(), 0);
        if (want_count >= 0) chk("instr_count", instr_count, want_count);
        chk("next_state", state, halt ? 3'd6 : 3'd1);
        if (is_ld || is_st) chk("stall_count", stall_count, stall_ref());
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_fetch", state, 3'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; zero_in = 1'b0;
        set_flags(-1);
        #2;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_instr", instr_count, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_pc_write", pc_write, 0);
        #10 reset = 1'b0;
        tick();
        chk("idle_hold", state, 0);

        // R-type, load with waits, branches, load/store conflict, store.
        do_start();
        run_instr(K_R, 0, 1'b0, 1'b0);
        run_instr(K_LD, 3, 1'b0, 1'b0);
        run_instr(K_CBZ, 0, 1'b1, 1'b0);
        run_instr(K_CBZ, 0, 1'b0, 1'b0);
        run_instr(K_B, 0, 1'b0, 1'b0);
        run_instr(K_BOTH, 1, 1'b0, 1'b0);
        run_instr(K_ST, 2, 1'b0, 1'b0);
        run_instr(K_ST, 0, 1'b0, 1'b0);

        // Halt after an R-type, then resume.
        run_instr(K_R, 0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("halt_state", state, 3'd6);
            chk("halt_ir_load", ir_load, 0);
            chk("halt_busy", busy, 0);
            tick();
        end
        do_start();
        run_instr(K_R, 0, 1'b0, 1'b0);

        // Store that never sees mem_ready: timeout into ERROR.
        set_flags(K_ST);
        mem_ready = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            chk("to_pre_state", state, s);
            tick();
        end
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            chk("to_mem_state", state, 3'd4);
            chk("to_mem_write_en", mem_write_en, 1);
            chk("to_pc_write", pc_write, 0);
            tick();
        end
        stall_exp += MEM_TIMEOUT;
        chk("err_state", state, 3'd7);
        chk("err_timeout", timeout_err, 1);
        chk("err_busy", busy, 0);
        chk("err_mem_write_en", mem_write_en, 0);
        chk("err_stall", stall_count, stall_ref());
        chk("err_instr", instr_count, instr_exp);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("err_start_ignored", state, 3'd7);
        chk("err_sticky", timeout_err, 1);
        reset = 1'b1;
        #1;
        chk("err_rst_state", state, 0);
        chk("err_rst_timeout", timeout_err, 0);
        #3 reset = 1'b0;
        instr_exp = 0;
        stall_exp = 0;
        tick();

        // Reset asynchronously in the middle of a load's MEMORY wait.
        do_start();
        run_instr(K_R, 0, 1'b0, 1'b0);
        set_flags(K_LD);
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_state", state, 3'd4);
        chk("mid_mem_read_en", mem_read_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mem_read_en", mem_read_en, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_instr", instr_count, 0);
        chk("mid_rst_stall", stall_count, 0);
        chk("mid_rst_busy", busy, 0);
        #3 reset = 1'b0;
        tick();
        chk("mid_rst_idle", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
